// File: rtl/tv80_alu16_pkg.sv
// tv80_alu16_pkg: op codes, ALU_Op values, Z80 flag bit positions and sequencer
// states shared by the 16-bit ALU sequencer.
package tv80_alu16_pkg;

    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_ADC16 = 2'b01;
    localparam logic [1:0] OP_SPREL = 2'b10;
    localparam logic [1:0] OP_SBC16 = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_SBC = 4'b0011;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_X = 3;
    localparam int FLAG_H = 4;
    localparam int FLAG_Y = 5;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq: runs ADD/ADC/SBC 16-bit through an external 8-bit tv80_alu, low byte first.
// Optional Gameboy ADD SP,e8 on op 10 when built with TV80_ALU16_SEQ_SPREL_EN and Mode == 3.
module tv80_alu16_seq
    import tv80_alu16_pkg::*;
#(
    parameter int Mode = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [7:0]  f_out,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    output logic        alu_arith16,
    output logic        alu_z16,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f
);

`ifdef TV80_ALU16_SEQ_SPREL_EN
    localparam bit SPREL_EN = 1'b1;
`else
    localparam bit SPREL_EN = 1'b0;
`endif

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [1:0]  r_op;
    logic [7:0]  r_fin;
    logic [7:0]  r_flo;
    logic [15:0] r_q;
    logic [7:0]  r_fout;
    logic        w_accept;
    logic        w_sprel;
    logic [15:0] w_b_eff;
    logic [7:0]  w_f_final;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sprel  = SPREL_EN && (Mode == 3) && (r_op == OP_SPREL);
    assign w_b_eff  = w_sprel ? {{8{r_b[7]}}, r_b[7:0]} : r_b;
    assign q        = r_q;
    assign f_out    = r_fout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_LO;
            ST_LO:   w_state_next = ST_HI;
            ST_HI:   w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_LO : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        alu_op      = ALU_ADD;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_f_in    = 8'h00;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        case (r_state)
            ST_LO: begin
                busy     = 1'b1;
                alu_busa = r_a[7:0];
                alu_busb = w_b_eff[7:0];
                alu_f_in = r_fin;
                case (r_op)
                    OP_ADC16: alu_op = ALU_ADC;
                    OP_SBC16: alu_op = ALU_SBC;
                    default: begin
                        alu_op      = ALU_ADD;
                        alu_arith16 = 1'b1;
                    end
                endcase
            end
            ST_HI: begin
                busy     = 1'b1;
                alu_busa = r_a[15:8];
                alu_busb = w_b_eff[15:8];
                alu_f_in = r_flo;
                // The high byte always consumes the low byte's carry; Z16 folds in the low-byte Z.
                case (r_op)
                    OP_ADC16: begin
                        alu_op  = ALU_ADC;
                        alu_z16 = 1'b1;
                    end
                    OP_SBC16: begin
                        alu_op  = ALU_SBC;
                        alu_z16 = 1'b1;
                    end
                    default: begin
                        alu_op      = ALU_ADC;
                        alu_arith16 = 1'b1;
                    end
                endcase
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ADD SP,e8 reports the low-byte carries and clears Z/N, keeping the rest of f_in.
    always_comb begin
        w_f_final = alu_f;
        if (w_sprel) begin
            w_f_final         = r_fin;
            w_f_final[FLAG_H] = r_flo[FLAG_H];
            w_f_final[FLAG_C] = r_flo[FLAG_C];
            w_f_final[FLAG_Z] = 1'b0;
            w_f_final[FLAG_N] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a    <= 16'h0000;
            r_b    <= 16'h0000;
            r_op   <= OP_ADD16;
            r_fin  <= 8'h00;
            r_flo  <= 8'h00;
            r_q    <= 16'h0000;
            r_fout <= 8'h00;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_fin <= f_in;
            end
            if (r_state == ST_LO) begin
                r_q[7:0] <= alu_q;
                r_flo    <= alu_f;
            end
            if (r_state == ST_HI) begin
                r_q[15:8] <= alu_q;
                r_fout    <= w_f_final;
            end
        end
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb_tv80_alu16_seq: random + directed scoreboard bench for tv80_alu16_seq with an 8-bit ALU stand-in.
// Build with TV80_ALU16_SEQ_SPREL_EN to also exercise the Gameboy ADD SP,e8 path (Mode = 3).
module tb_tv80_alu16_seq;

`ifdef TV80_ALU16_SEQ_SPREL_EN
    localparam int TB_MODE  = 3;
    localparam bit SPREL_ON = 1'b1;
`else
    localparam int TB_MODE  = 0;
    localparam bit SPREL_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_f_in;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f;

    tv80_alu16_seq #(.Mode(TB_MODE)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .f_in(f_in),
        .busy(busy), .done(done), .q(q), .f_out(f_out),
        .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
        .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_q(alu_q), .alu_f(alu_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU stand-in: Z80 byte add/sub with carry, Arith16 keeps S/Z/P, Z16 chains Z.
    logic [8:0] m_s;
    logic [4:0] m_h;
    logic       m_cin;
    logic       m_sub;
    logic       m_ov;
    logic       m_z;
    always_comb begin
        m_sub = alu_op[1];
        m_cin = (alu_op[0] && !alu_op[2]) ? alu_f_in[0] : 1'b0;
        if (m_sub) begin
            m_s  = {1'b0, alu_busa} - {1'b0, alu_busb} - 9'(m_cin);
            m_h  = {1'b0, alu_busa[3:0]} - {1'b0, alu_busb[3:0]} - 5'(m_cin);
            m_ov = (alu_busa[7] != alu_busb[7]) && (m_s[7] != alu_busa[7]);
        end else begin
            m_s  = {1'b0, alu_busa} + {1'b0, alu_busb} + 9'(m_cin);
            m_h  = {1'b0, alu_busa[3:0]} + {1'b0, alu_busb[3:0]} + 5'(m_cin);
            m_ov = (alu_busa[7] == alu_busb[7]) && (m_s[7] != alu_busa[7]);
        end
        m_z   = (m_s[7:0] == 8'h00) ? (alu_z16 ? alu_f_in[6] : 1'b1) : 1'b0;
        alu_q = m_s[7:0];
        alu_f = {m_s[7], m_z, m_s[5], m_h[4], m_s[3], m_ov, m_sub, m_s[8]};
        if (alu_arith16) begin
            alu_f[7] = alu_f_in[7];
            alu_f[6] = alu_f_in[6];
            alu_f[2] = alu_f_in[2];
        end
    end

    typedef struct {
        logic [15:0] q;
        logic [7:0]  f;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_end = -10;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // 16-bit reference: whole-word arithmetic, flags from the Z80 16-bit rules.
    function automatic logic [23:0] ref_model(input logic [1:0] o, input logic [15:0] x,
                                              input logic [15:0] y, input logic [7:0] fi);
        int xi, yi, ci, r, hr;
        logic [15:0] rq;
        logic [7:0]  rf;
        xi = int'(x);
        yi = int'(y);
        ci = int'(fi[0]);
        if (o == 2'b10 && SPREL_ON) begin
            yi = int'({{8{y[7]}}, y[7:0]});
            r  = xi + yi;
            rq = r[15:0];
            rf = fi;
            rf[6] = 1'b0;
            rf[1] = 1'b0;
            rf[4] = ((xi & 15) + int'(y[3:0])) > 15;
            rf[0] = ((xi & 255) + int'(y[7:0])) > 255;
        end else if (o == 2'b11) begin
            r  = xi - yi - ci;
            hr = (xi & 'hFFF) - (yi & 'hFFF) - ci;
            rq = r[15:0];
            rf = {rq[15], rq == 16'h0, rq[13], hr < 0, rq[11],
                  (x[15] != y[15]) && (rq[15] != x[15]), 1'b1, r < 0};
        end else if (o == 2'b01) begin
            r  = xi + yi + ci;
            hr = (xi & 'hFFF) + (yi & 'hFFF) + ci;
            rq = r[15:0];
            rf = {rq[15], rq == 16'h0, rq[13], hr > 'hFFF, rq[11],
                  (x[15] == y[15]) && (rq[15] != x[15]), 1'b0, r > 'hFFFF};
        end else begin
            r  = xi + yi;
            hr = (xi & 'hFFF) + (yi & 'hFFF);
            rq = r[15:0];
            rf = {fi[7], fi[6], rq[13], hr > 'hFFF, rq[11], fi[2], 1'b0, r > 'hFFFF};
        end
        return {rq, rf};
    endfunction

    task automatic drive(input logic st, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [7:0] fv);
        @(posedge clk);
        #2;
        start = st;
        op    = o;
        a     = x;
        b     = y;
        f_in  = fv;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00, 16'h0, 16'h0, 8'h0);
    endtask

    // Start is only taken when the bench's occupancy model says the sequencer is free.
    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] fv, input logic [15:0] eq, input logic [7:0] ef);
        exp_t e;
        drive(1'b1, o, x, y, fv);
        if (cyc > busy_end) begin
            e.q   = eq;
            e.f   = ef;
            e.cyc = cyc + 3;
            sb.push_back(e);
            busy_end = cyc + 2;
        end
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic issue_rand();
        logic [1:0]  o;
        logic [15:0] x, y;
        logic [7:0]  fv;
        logic [23:0] r;
        o  = 2'($urandom_range(0, 3));
        x  = pick16();
        y  = pick16();
        fv = 8'($urandom);
        r  = ref_model(o, x, y, fv);
        issue(o, x, y, fv, r[23:8], r[7:0]);
    endtask

    // Monitor: done must appear exactly in the cycle each scoreboard entry predicts.
    always @(negedge clk) begin
        exp_t e;
        chk("busy", busy, (busy_end >= cyc) && (busy_end <= cyc + 1));
        if (sb.size() == 0) begin
            chk("no_done", done, 1'b0);
        end else if (sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("done", done, 1'b1);
            chk("q", q, e.q);
            chk("f_out", f_out, e.f);
        end else begin
            chk("done_early", done, 1'b0);
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = 16'h0;
        b       = 16'h0;
        f_in    = 8'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", q, 16'h0);
        chk("rst_f_out", f_out, 8'h0);
        chk("rst_alu_drive", {alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}, 0);
        reset_n = 1'b1;
        idle(2);

        issue(2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
        idle(3);
        issue(2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51);
        idle(3);
        issue(2'b01, 16'h0100, 16'hFF00, 8'h00, 16'h0000, 8'h51);
        idle(2);
        issue(2'b01, 16'h0001, 16'h00FF, 8'h00, 16'h0100, 8'h00);
        idle(3);
        issue(2'b11, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E);
        issue(2'b00, 16'h1234, 16'h1111, 8'h00, 16'h2345, 8'h00);
        issue(2'b01, 16'h4321, 16'h1111, 8'hFF, 16'h5433, 8'h00);
        idle(3);
`ifdef TV80_ALU16_SEQ_SPREL_EN
        issue(2'b10, 16'hFFF8, 16'h0008, 8'h00, 16'h0000, 8'h11);
        idle(3);
`endif

        // Abort an operation in its high-byte cycle.
        issue(2'b01, 16'h1234, 16'h4321, 8'h01, 16'h5556, 8'h00);
        idle(1);
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        sb.delete();
        busy_end = -10;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_q", q, 16'h0);
        chk("abort_f_out", f_out, 8'h0);
        chk("abort_alu_op", alu_op, 4'h0);
        idle(2);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(6);

        for (int i = 0; i < 200; i++) begin
            issue_rand();
            idle($urandom_range(2, 4));
        end

        idle(8);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
